// File: rtl/param_tx_serializer_if.sv
// Word-in / bit-out bus of the parametrised TX serializer.
// A word transfers on a rising CLK edge where in_valid && in_ready; in_data,
// in_msb_first and in_par_odd must be held stable while in_valid is high and
// in_ready is low, and in_ready never depends combinationally on in_valid.
interface param_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_msb_first;
  logic                  in_par_odd;
  logic                  in_valid;
  logic                  in_ready;
  logic                  ser_out;
  logic                  par_bit;
  logic                  busy;
  logic                  ser_done;

  modport master (
    output in_data, in_msb_first, in_par_odd, in_valid,
    input  in_ready, ser_out, par_bit, busy, ser_done
  );

  modport slave (
    input  in_data, in_msb_first, in_par_odd, in_valid,
    output in_ready, ser_out, par_bit, busy, ser_done
  );
endinterface

// File: rtl/param_tx_serializer.sv
// Parametrised TX serializer: one-word holding buffer feeding a shift register
// that emits one bit per EN strobe, with per-word bit order and parity type.
module param_tx_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1,
  localparam int  CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  param_tx_serializer_if.slave bus,
  output logic             state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sreg;
  logic                  order_msb;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_msb;
  logic                  hold_odd;
  logic                  hold_full;
  logic                  ser_out_q;
  logic                  par_bit_q;
  logic                  ser_done_q;
  logic                  transfer;
  logic                  emit_bit;
  logic [DATA_WIDTH-1:0] sreg_shifted;
  logic                  load_par;

  assign transfer     = bus.in_valid && !hold_full;
  assign emit_bit     = order_msb ? sreg[DATA_WIDTH-1] : sreg[0];
  assign sreg_shifted = order_msb ? (sreg << 1) : (sreg >> 1);
  assign load_par     = (^hold_data) ^ hold_odd;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      order_msb  <= 1'b0;
      hold_data  <= '0;
      hold_msb   <= 1'b0;
      hold_odd   <= 1'b0;
      hold_full  <= 1'b0;
      ser_out_q  <= IDLE_LEVEL;
      par_bit_q  <= 1'b0;
      ser_done_q <= 1'b0;
    end else begin
      ser_done_q <= 1'b0;

      // Transfer only when empty and load only when full, so the two
      // hold_full updates below can never collide.
      if (transfer) begin
        hold_data <= bus.in_data;
        hold_msb  <= bus.in_msb_first;
        hold_odd  <= bus.in_par_odd;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          ser_out_q <= IDLE_LEVEL;
          if (hold_full) begin
            sreg      <= hold_data;
            order_msb <= hold_msb;
            par_bit_q <= load_par;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (EN) begin
            if (cnt < CNT_LAST) begin
              ser_out_q <= emit_bit;
              sreg      <= sreg_shifted;
              cnt       <= cnt + 1'b1;
            end else begin
              // Stop period of the word: pulse done and reload if a word waits.
              ser_done_q <= 1'b1;
              ser_out_q  <= IDLE_LEVEL;
              if (hold_full) begin
                sreg      <= hold_data;
                order_msb <= hold_msb;
                par_bit_q <= load_par;
                cnt       <= '0;
                hold_full <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = !hold_full;
  assign bus.ser_out  = ser_out_q;
  assign bus.par_bit  = par_bit_q;
  assign bus.busy     = (state == SHIFT);
  assign bus.ser_done = ser_done_q;
  assign state_dbg    = state;
  assign cnt_dbg      = cnt;

endmodule

// File: tb/tb_param_tx_serializer.sv
// Directed bench for param_tx_serializer: an 8-bit instance for framing,
// ordering, back-to-back, stall and reset cases, and a 12-bit instance.
module tb_param_tx_serializer;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic EN  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int done_cnt8 = 0;

  param_tx_serializer_if #(.DATA_WIDTH(8))  bus8 ();
  param_tx_serializer_if #(.DATA_WIDTH(12)) bus12 ();

  logic       state8_dbg;
  logic [3:0] cnt8_dbg;
  logic       state12_dbg;
  logic [3:0] cnt12_dbg;

  param_tx_serializer #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .bus(bus8),
    .state_dbg(state8_dbg), .cnt_dbg(cnt8_dbg)
  );

  param_tx_serializer #(.DATA_WIDTH(12)) dut12 (
    .CLK(CLK), .RST(RST), .EN(EN), .bus(bus12),
    .state_dbg(state12_dbg), .cnt_dbg(cnt12_dbg)
  );

  // clock / reset / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  always @(negedge CLK) if (bus8.ser_done) done_cnt8++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks; all return positioned on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic en_edge();
    @(negedge CLK) EN = 1'b1;
    @(negedge CLK) EN = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic msb, input logic odd);
    @(negedge CLK);
    bus8.in_data      = d;
    bus8.in_msb_first = msb;
    bus8.in_par_odd   = odd;
    bus8.in_valid     = 1'b1;
    @(negedge CLK);
    bus8.in_valid     = 1'b0;
  endtask

  // seq bit i is the i-th serial bit expected on ser_out
  task automatic shift_bits8(input string tag, input logic [7:0] seq, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      idle(3);
      en_edge();
      check({tag, "_bit"}, 32'(bus8.ser_out), 32'(seq[i]));
      check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus8.ser_done), 32'd0);
    end
  endtask

  task automatic finish_word8(input string tag);
    idle(3);
    en_edge();
    check({tag, "_done"}, 32'(bus8.ser_done), 32'd1);
    check({tag, "_stop_idle"}, 32'(bus8.ser_out), 32'd1);
    @(negedge CLK);
    check({tag, "_done_1cyc"}, 32'(bus8.ser_done), 32'd0);
  endtask

  logic [11:0] seq12;
  int          done_before;

  initial begin
    bus8.in_data = '0;  bus8.in_msb_first = 1'b0;  bus8.in_par_odd = 1'b0;  bus8.in_valid = 1'b0;
    bus12.in_data = '0; bus12.in_msb_first = 1'b0; bus12.in_par_odd = 1'b0; bus12.in_valid = 1'b0;

    // 1: reset
    RST = 1'b0;
    idle(3);
    RST = 1'b1;
    idle(1);
    check("rst_ser_out", 32'(bus8.ser_out), 32'd1);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_ser_done", 32'(bus8.ser_done), 32'd0);
    check("rst_par_bit", 32'(bus8.par_bit), 32'd0);
    check("rst_state", 32'(state8_dbg), 32'd0);
    check("rst12_ser_out", 32'(bus12.ser_out), 32'd1);
    check("rst12_busy", 32'(bus12.busy), 32'd0);

    // 2: 0xA5 LSB-first even -> 1,0,1,0,0,1,0,1
    done_before = done_cnt8;
    send8(8'hA5, 1'b0, 1'b0);
    check("t2_ready_full", 32'(bus8.in_ready), 32'd0);
    idle(1);
    check("t2_busy_load", 32'(bus8.busy), 32'd1);
    check("t2_ready_after_load", 32'(bus8.in_ready), 32'd1);
    check("t2_par", 32'(bus8.par_bit), 32'd0);
    check("t2_idle_before_en", 32'(bus8.ser_out), 32'd1);
    shift_bits8("t2", 8'hA5, 0, 7);
    idle(3);
    en_edge();
    check("t2_done", 32'(bus8.ser_done), 32'd1);
    check("t2_busy_drop", 32'(bus8.busy), 32'd0);
    check("t2_stop_idle", 32'(bus8.ser_out), 32'd1);
    @(negedge CLK);
    check("t2_done_1cyc", 32'(bus8.ser_done), 32'd0);
    check("t2_done_count", 32'(done_cnt8 - done_before), 32'd1);

    // 3: 0xA5 MSB-first odd -> 1,0,1,0,0,1,0,1 and par 1
    send8(8'hA5, 1'b1, 1'b1);
    idle(1);
    check("t3_par", 32'(bus8.par_bit), 32'd1);
    shift_bits8("t3", 8'hA5, 0, 7);
    finish_word8("t3");
    check("t3_busy_end", 32'(bus8.busy), 32'd0);

    // 4: back-to-back 0x01 then 0x80, both LSB-first even
    done_before = done_cnt8;
    @(negedge CLK);
    bus8.in_data = 8'h01; bus8.in_msb_first = 1'b0; bus8.in_par_odd = 1'b0; bus8.in_valid = 1'b1;
    @(negedge CLK);
    bus8.in_data = 8'h80;
    check("t4_ready_low_pre_load", 32'(bus8.in_ready), 32'd0);
    @(negedge CLK);
    check("t4_busy_first", 32'(bus8.busy), 32'd1);
    check("t4_ready_after_load", 32'(bus8.in_ready), 32'd1);
    check("t4_par_first", 32'(bus8.par_bit), 32'd1);
    @(negedge CLK);
    bus8.in_valid = 1'b0;
    check("t4_ready_second_held", 32'(bus8.in_ready), 32'd0);
    shift_bits8("t4a", 8'h01, 0, 7);
    finish_word8("t4a");
    check("t4_busy_reload", 32'(bus8.busy), 32'd1);
    check("t4_par_second", 32'(bus8.par_bit), 32'd1);
    check("t4_ready_after_reload", 32'(bus8.in_ready), 32'd1);
    shift_bits8("t4b", 8'h80, 0, 7);
    finish_word8("t4b");
    check("t4_busy_end", 32'(bus8.busy), 32'd0);
    check("t4_done_count", 32'(done_cnt8 - done_before), 32'd2);

    // 5: 0xC4 MSB-first even -> 1,1,0,0,0,1,0,0 ; stall 20 cycles after 3 bits
    send8(8'hC4, 1'b1, 1'b0);
    idle(1);
    check("t5_par", 32'(bus8.par_bit), 32'd1);
    shift_bits8("t5", 8'h23, 0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("t5_stall_out", 32'(bus8.ser_out), 32'd0);
      check("t5_stall_busy", 32'(bus8.busy), 32'd1);
      check("t5_stall_cnt", 32'(cnt8_dbg), 32'd3);
    end
    shift_bits8("t5", 8'h23, 3, 7);
    finish_word8("t5");

    // 6: reset after bit 4 with a second word buffered
    done_before = done_cnt8;
    send8(8'h5A, 1'b0, 1'b0);
    idle(1);
    send8(8'h33, 1'b0, 1'b0);
    check("t6_hold_full", 32'(bus8.in_ready), 32'd0);
    shift_bits8("t6", 8'h5A, 0, 3);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    check("t6_rst_ser_out", 32'(bus8.ser_out), 32'd1);
    check("t6_rst_busy", 32'(bus8.busy), 32'd0);
    check("t6_rst_ready", 32'(bus8.in_ready), 32'd1);
    check("t6_rst_par", 32'(bus8.par_bit), 32'd0);
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle(2);
      en_edge();
      check("t6_no_resid_out", 32'(bus8.ser_out), 32'd1);
      check("t6_no_resid_busy", 32'(bus8.busy), 32'd0);
    end
    check("t6_no_done", 32'(done_cnt8 - done_before), 32'd0);

    // 6b: 12-bit instance, 0xF0F LSB-first even
    seq12 = 12'hF0F;
    @(negedge CLK);
    bus12.in_data = 12'hF0F; bus12.in_msb_first = 1'b0; bus12.in_par_odd = 1'b0; bus12.in_valid = 1'b1;
    @(negedge CLK);
    bus12.in_valid = 1'b0;
    idle(1);
    check("t7_busy", 32'(bus12.busy), 32'd1);
    check("t7_par", 32'(bus12.par_bit), 32'd0);
    for (int i = 0; i < 12; i++) begin
      idle(3);
      en_edge();
      check("t7_bit", 32'(bus12.ser_out), 32'(seq12[i]));
      check("t7_nodone", 32'(bus12.ser_done), 32'd0);
    end
    idle(3);
    en_edge();
    check("t7_done", 32'(bus12.ser_done), 32'd1);
    check("t7_busy_drop", 32'(bus12.busy), 32'd0);
    check("t7_stop_idle", 32'(bus12.ser_out), 32'd1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
